ctech_lib_clk_or_en_mc: RTL and testbench

Multi-channel, self-timed clock-gating controller built on the OR-type clock gate `ctech_lib_clk_or_en`. In that cell, en=1 parks clkout high.
- Each channel tracks activity and closes its gate after a programmable idle window.
- It reopens on demand, then holds off a ready flag for a fixed wake delay.
- It sits at a clock-domain root, ahead of leaf functional blocks, replacing hand-wired single-channel gates.

---
 rtl/ctech_lib_clk_or_en_mc_if.sv | 23 ++
 rtl/ctech_lib_clk_or_en_mc.sv | 142 ++++++++++++++
 tb/tb_ctech_lib_clk_or_en_mc.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ctech_lib_clk_or_en_mc_if.sv
// Channel-side bundle for the multi-channel OR-type clock-gating controller:
// activity/threshold/test-override inputs and per-channel gated clocks plus status.
interface ctech_lib_clk_or_en_mc_if #(
    parameter int NUM_CH = 4,
    parameter int IDLE_W = 8
) ();
    logic [NUM_CH-1:0] act;
    logic [IDLE_W-1:0] idle_thresh;
    logic              te;
    logic [NUM_CH-1:0] clkout;
    logic [NUM_CH-1:0] gated;
    logic [NUM_CH-1:0] rdy;

    modport master (
        output act, idle_thresh, te,
        input  clkout, gated, rdy
    );

    modport slave (
        input  act, idle_thresh, te,
        output clkout, gated, rdy
    );
endinterface

// File: rtl/ctech_lib_clk_or_en_mc.sv
// Self-timed multi-channel clock gating built on OR-type gates: each channel parks
// its clock high after an idle window and reopens on demand with a fixed wake delay.
module ctech_lib_clk_or_en (
    input  logic clk,
    input  logic en,
    output logic clkout
);
    // en only moves while clk is high, so the OR never produces a short low pulse
    assign clkout = clk | en;
endmodule

module ctech_lib_clk_or_en_mc #(
    parameter int NUM_CH   = 4,
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    ctech_lib_clk_or_en_mc_if.slave bus
);
    localparam int WAKE_W = $clog2(WAKE_CYC + 1);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYC - 1);
    localparam logic [WAKE_W-1:0] WAKE_ONE  = WAKE_W'(1'b1);
    localparam logic [IDLE_W:0]   IDLE_ONE  = (IDLE_W + 1)'(1'b1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = {IDLE_W{1'b1}};
    localparam logic [IDLE_W-1:0] IDLE_ZERO = {IDLE_W{1'b0}};
    localparam logic [WAKE_W-1:0] WAKE_ZERO = {WAKE_W{1'b0}};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_GATED = 2'd1,
        ST_WAKE  = 2'd2
    } state_t;

    state_t            state_r      [NUM_CH];
    state_t            state_nxt_s  [NUM_CH];
    logic [IDLE_W-1:0] idle_r       [NUM_CH];
    logic [IDLE_W-1:0] idle_nxt_s   [NUM_CH];
    logic [WAKE_W-1:0] wake_r       [NUM_CH];
    logic [WAKE_W-1:0] wake_nxt_s   [NUM_CH];
    logic [NUM_CH-1:0] en_r;
    logic [NUM_CH-1:0] en_nxt_s;
    logic [NUM_CH-1:0] rdy_r;
    logic [NUM_CH-1:0] rdy_nxt_s;
    logic [NUM_CH-1:0] clkout_s;

    // Per-channel next-state: test override first, then the RUN/GATED/WAKE machine
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_nxt_s[i] = state_r[i];
            idle_nxt_s[i]  = idle_r[i];
            wake_nxt_s[i]  = wake_r[i];
            en_nxt_s[i]    = en_r[i];
            rdy_nxt_s[i]   = rdy_r[i];
            if (bus.te) begin
                state_nxt_s[i] = ST_RUN;
                idle_nxt_s[i]  = IDLE_ZERO;
                wake_nxt_s[i]  = WAKE_ZERO;
                en_nxt_s[i]    = 1'b0;
                rdy_nxt_s[i]   = 1'b1;
            end else begin
                case (state_r[i])
                    ST_RUN: begin
                        if (bus.act[i]) begin
                            idle_nxt_s[i] = IDLE_ZERO;
                        end else if ((bus.idle_thresh != IDLE_ZERO) &&
                                     (({1'b0, idle_r[i]} + IDLE_ONE) >= {1'b0, bus.idle_thresh})) begin
                            state_nxt_s[i] = ST_GATED;
                            idle_nxt_s[i]  = IDLE_ZERO;
                            en_nxt_s[i]    = 1'b1;
                            rdy_nxt_s[i]   = 1'b0;
                        end else if (idle_r[i] != IDLE_MAX) begin
                            idle_nxt_s[i] = idle_r[i] + IDLE_ONE[IDLE_W-1:0];
                        end else begin
                            idle_nxt_s[i] = IDLE_MAX;
                        end
                    end
                    ST_GATED: begin
                        if (bus.act[i]) begin
                            state_nxt_s[i] = ST_WAKE;
                            wake_nxt_s[i]  = WAKE_ZERO;
                            en_nxt_s[i]    = 1'b0;
                        end else begin
                            state_nxt_s[i] = ST_GATED;
                        end
                    end
                    ST_WAKE: begin
                        // act is deliberately ignored: a started wake always completes
                        if (wake_r[i] == WAKE_LAST) begin
                            state_nxt_s[i] = ST_RUN;
                            idle_nxt_s[i]  = IDLE_ZERO;
                            wake_nxt_s[i]  = WAKE_ZERO;
                            rdy_nxt_s[i]   = 1'b1;
                        end else begin
                            wake_nxt_s[i] = wake_r[i] + WAKE_ONE;
                        end
                    end
                    default: begin
                        state_nxt_s[i] = ST_RUN;
                        idle_nxt_s[i]  = IDLE_ZERO;
                        wake_nxt_s[i]  = WAKE_ZERO;
                        en_nxt_s[i]    = 1'b0;
                        rdy_nxt_s[i]   = 1'b1;
                    end
                endcase
            end
        end
    end

    // State, counters, gate enables and ready flags; reset reopens every gate
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_r[i] <= ST_RUN;
                idle_r[i]  <= IDLE_ZERO;
                wake_r[i]  <= WAKE_ZERO;
            end
            en_r  <= {NUM_CH{1'b0}};
            rdy_r <= {NUM_CH{1'b1}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_r[i] <= state_nxt_s[i];
                idle_r[i]  <= idle_nxt_s[i];
                wake_r[i]  <= wake_nxt_s[i];
            end
            en_r  <= en_nxt_s;
            rdy_r <= rdy_nxt_s;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ctech_lib_clk_or_en u_gate (
            .clk    (clk),
            .en     (en_r[g]),
            .clkout (clkout_s[g])
        );
    end

    assign bus.clkout = clkout_s;
    assign bus.gated  = en_r;
    assign bus.rdy    = rdy_r;
endmodule

// File: tb/tb_ctech_lib_clk_or_en_mc.sv
// Directed bench for the multi-channel OR clock-gating controller: a table of
// per-cycle vectors with hand-derived gated/rdy/clkout, plus long-run sequences.
`timescale 1ns/1ps
module tb_ctech_lib_clk_or_en_mc;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   glitch_cnt;

    ctech_lib_clk_or_en_mc_if #(.NUM_CH(4), .IDLE_W(8)) bus_if ();

    ctech_lib_clk_or_en_mc #(.NUM_CH(4), .IDLE_W(8), .WAKE_CYC(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        logic       rst;
        logic [3:0] act;
        logic [7:0] th;
        logic       te;
        logic [3:0] eg;
        logic [3:0] er;
    } vec_t;

    vec_t vecs [64];
    int   nvec;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Low-pulse width monitor on every gated clock
    realtime    fall_t [4];
    logic [3:0] prev_clkout;
    initial begin
        glitch_cnt  = 0;
        prev_clkout = 4'bxxxx;
        for (int i = 0; i < 4; i++) fall_t[i] = -1.0;
    end
    always @(bus_if.clkout) begin
        for (int i = 0; i < 4; i++) begin
            if (prev_clkout[i] === 1'b1 && bus_if.clkout[i] === 1'b0) begin
                fall_t[i] = $realtime;
            end else if (prev_clkout[i] === 1'b0 && bus_if.clkout[i] === 1'b1) begin
                if (fall_t[i] >= 0.0 && ($realtime - fall_t[i]) < 4.999) glitch_cnt++;
            end
        end
        prev_clkout = bus_if.clkout;
    end

    task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] a, input logic [7:0] th,
                       input logic te, input logic [3:0] eg, input logic [3:0] er);
        vecs[nvec].rst = r;
        vecs[nvec].act = a;
        vecs[nvec].th  = th;
        vecs[nvec].te  = te;
        vecs[nvec].eg  = eg;
        vecs[nvec].er  = er;
        nvec++;
    endtask

    task automatic drive(input logic r, input logic [3:0] a, input logic [7:0] th, input logic te);
        rst                = r;
        bus_if.act         = a;
        bus_if.idle_thresh = th;
        bus_if.te          = te;
    endtask

    // One cycle: outputs after the edge, then clkout in the low phase (equals gate enable)
    task automatic cyc(input string nm, input logic [3:0] eg, input logic [3:0] er);
        @(posedge clk); #1;
        chk({nm, " gated"}, bus_if.gated, eg);
        chk({nm, " rdy"}, bus_if.rdy, er);
        @(negedge clk); #1;
        chk({nm, " clkout_low_phase"}, bus_if.clkout, eg);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        nvec     = 0;
        drive(1'b1, 4'b0000, 8'd0, 1'b0);
        @(negedge clk); #1;

        // Reset state, then 50 idle cycles with auto-gating disabled
        cyc("reset", 4'b0000, 4'b1111);
        drive(1'b0, 4'b0000, 8'd0, 1'b0);
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            chk("thr0 gated", bus_if.gated, 4'b0000);
            chk("thr0 rdy", bus_if.rdy, 4'b1111);
            chk("thr0 clkout_high", bus_if.clkout, 4'b1111);
            @(negedge clk); #1;
            chk("thr0 clkout_low", bus_if.clkout, 4'b0000);
        end

        // ch0 idle gate with threshold 5 and wake via 1-cycle act pulse
        add(0, 4'b1111, 8'd5, 0, 4'b0000, 4'b1111);
        for (int k = 0; k < 4; k++) add(0, 4'b1110, 8'd5, 0, 4'b0000, 4'b1111);
        add(0, 4'b1110, 8'd5, 0, 4'b0001, 4'b1110);
        add(0, 4'b1110, 8'd5, 0, 4'b0001, 4'b1110);
        add(0, 4'b1111, 8'd5, 0, 4'b0000, 4'b1110);
        add(0, 4'b1110, 8'd5, 0, 4'b0000, 4'b1110);
        add(0, 4'b1110, 8'd5, 0, 4'b0000, 4'b1111);
        add(0, 4'b1111, 8'd3, 0, 4'b0000, 4'b1111);
        // ch1: act returns exactly on the threshold cycle, then three idle cycles gate
        add(0, 4'b1101, 8'd3, 0, 4'b0000, 4'b1111);
        add(0, 4'b1101, 8'd3, 0, 4'b0000, 4'b1111);
        add(0, 4'b1111, 8'd3, 0, 4'b0000, 4'b1111);
        add(0, 4'b1101, 8'd3, 0, 4'b0000, 4'b1111);
        add(0, 4'b1101, 8'd3, 0, 4'b0000, 4'b1111);
        add(0, 4'b1101, 8'd3, 0, 4'b0010, 4'b1101);
        // ch3: six idle cycles at threshold 10, then lowering to 2 gates at once
        for (int k = 0; k < 6; k++) add(0, 4'b0101, 8'd10, 0, 4'b0010, 4'b1101);
        add(0, 4'b0101, 8'd2, 0, 4'b1010, 4'b0101);
        // ch1 mid-wake, ch3 gated, then te forces everything open
        add(0, 4'b0111, 8'd2, 0, 4'b1000, 4'b0101);
        add(0, 4'b0000, 8'd4, 1, 4'b0000, 4'b1111);
        for (int k = 0; k < 3; k++) add(0, 4'b0000, 8'd4, 0, 4'b0000, 4'b1111);
        add(0, 4'b0000, 8'd4, 0, 4'b1111, 4'b0000);
        // ch1 mid-wake, others gated, then synchronous reset reopens all
        add(0, 4'b0010, 8'd4, 0, 4'b1101, 4'b0000);
        add(1, 4'b0000, 8'd4, 0, 4'b0000, 4'b1111);
        for (int k = 0; k < 3; k++) add(0, 4'b0000, 8'd4, 0, 4'b0000, 4'b1111);
        add(0, 4'b0000, 8'd4, 0, 4'b1111, 4'b0000);

        for (int v = 0; v < nvec; v++) begin
            drive(vecs[v].rst, vecs[v].act, vecs[v].th, vecs[v].te);
            cyc($sformatf("vec%0d", v), vecs[v].eg, vecs[v].er);
        end

        // Idle counter saturates: 300 idle cycles at threshold 0, then threshold 255 gates
        drive(1'b1, 4'b0000, 8'd0, 1'b0);
        cyc("sat reset", 4'b0000, 4'b1111);
        drive(1'b0, 4'b0000, 8'd0, 1'b0);
        repeat (300) @(posedge clk);
        #1;
        chk("sat no_gate", bus_if.gated, 4'b0000);
        @(negedge clk); #1;
        drive(1'b0, 4'b0000, 8'd255, 1'b0);
        cyc("sat gate", 4'b1111, 4'b0000);

        @(negedge clk); #1;
        n_checks++;
        if (glitch_cnt != 0) begin
            n_fail++;
            $display("FAIL clkout_glitch: got %0d short low pulses, expected 0", glitch_cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
